// File: rtl/tx_data_path.sv
// Transmit word datapath: input FIFO, PRBS7, fixed pattern and idle sources.
// Define TX_PRBS_EN to build the PRBS7 generator; otherwise mode 2 sends zeros.
module tx_data_path #(
   parameter int Nti   = 16,
   parameter int Nfifo = 4
) (
   input  logic                     clk_tx,
   input  logic                     rstb,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic [Nti-1:0]           in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Nti-1:0]           fixed_pattern,
   output logic [Nti-1:0]           tx_data,
   output logic                     tx_valid,
   output logic [$clog2(Nfifo):0]   fifo_level,
   output logic [15:0]              underflow_cnt
);

   localparam int AW = $clog2(Nfifo);
   localparam int LW = AW + 1;

   logic [Nti-1:0] r_mem [Nfifo];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [LW-1:0]  r_level;
   logic [Nti-1:0] r_tx;
   logic           r_valid;
   logic [15:0]    r_ucnt;

   logic           w_wr;
   logic           w_rd;
   logic           w_uf;
   logic [Nti-1:0] w_tx_next;
   logic [Nti-1:0] w_prbs_word;

   assign in_ready      = (r_level < LW'(Nfifo));
   assign fifo_level    = r_level;
   assign tx_data       = r_tx;
   assign tx_valid      = r_valid;
   assign underflow_cnt = r_ucnt;

   assign w_wr = en & in_valid & in_ready;

`ifdef TX_PRBS_EN
   logic [6:0] r_prbs;
   logic [1:0] r_mode_prev;
   logic [6:0] w_prbs_next;

   // Entering mode 2 restarts the sequence from the all-ones seed.
   always_comb begin
      logic b;
      w_prbs_next = (r_mode_prev != 2'd2) ? 7'h7F : r_prbs;
      w_prbs_word = '0;
      for (int i = 0; i < Nti; i++) begin
         b              = w_prbs_next[6] ^ w_prbs_next[5];
         w_prbs_word[i] = b;
         w_prbs_next    = {w_prbs_next[5:0], b};
      end
   end

   always_ff @(posedge clk_tx) begin
      if (!rstb) begin
         r_prbs      <= 7'h7F;
         r_mode_prev <= 2'd0;
      end else begin
         r_mode_prev <= mode;
         if (en && mode == 2'd2)
            r_prbs <= w_prbs_next;
      end
   end
`else
   assign w_prbs_word = '0;
`endif

   always_comb begin
      w_tx_next = '0;
      w_rd      = 1'b0;
      w_uf      = 1'b0;
      if (en) begin
         case (mode)
            2'd1: begin
               if (r_level != '0) begin
                  w_rd      = 1'b1;
                  w_tx_next = r_mem[r_rptr];
               end else begin
                  w_uf = 1'b1;
               end
            end
            2'd2:    w_tx_next = w_prbs_word;
            2'd3:    w_tx_next = fixed_pattern;
            default: w_tx_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk_tx) begin
      if (w_wr)
         r_mem[r_wptr] <= in_data;
   end

   // Dropping en flushes the FIFO; storage contents are simply abandoned.
   always_ff @(posedge clk_tx) begin
      if (!rstb || !en) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_rd)
            r_rptr <= r_rptr + 1'b1;
         r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      end
   end

   always_ff @(posedge clk_tx) begin
      if (!rstb) begin
         r_tx    <= '0;
         r_valid <= 1'b0;
         r_ucnt  <= '0;
      end else begin
         r_tx    <= w_tx_next;
         r_valid <= en;
         if (w_uf && r_ucnt != 16'hFFFF)
            r_ucnt <= r_ucnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_tx_data_path.sv
// Self-checking bench for tx_data_path against a queue-based reference model.
// PRBS expectations follow TX_PRBS_EN, matching the design build.
module tb_tx_data_path;

   localparam int NTI = 16;
   localparam int NF  = 4;

   logic           clk_tx = 1'b0;
   logic           rstb;
   logic           en;
   logic [1:0]     mode;
   logic [NTI-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic [NTI-1:0] fixed_pattern;
   logic [NTI-1:0] tx_data;
   logic           tx_valid;
   logic [2:0]     fifo_level;
   logic [15:0]    underflow_cnt;

   always #5 clk_tx = ~clk_tx;

   tx_data_path #(.Nti(NTI), .Nfifo(NF)) dut (
      .clk_tx        (clk_tx),
      .rstb          (rstb),
      .en            (en),
      .mode          (mode),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .fixed_pattern (fixed_pattern),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .fifo_level    (fifo_level),
      .underflow_cnt (underflow_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [NTI-1:0] m_q[$];
   logic [NTI-1:0] m_tx;
   logic           m_valid;
   int             m_ucnt;
   logic [1:0]     m_prev;
   bit             m_hist[$];

   // Seven ones of history: b[n] = b[n-6] ^ b[n-7]
   task automatic seed();
      m_hist.delete();
      for (int i = 0; i < 7; i++) m_hist.push_back(1'b1);
   endtask

   task automatic model_step();
      logic [NTI-1:0] nt;
      bit rdy;
`ifdef TX_PRBS_EN
      bit b;
`endif
      if (!rstb) begin
         m_q.delete();
         m_tx = '0;
         m_valid = 1'b0;
         m_ucnt = 0;
         m_prev = 2'd0;
         seed();
         return;
      end
      rdy = (m_q.size() < NF);
      nt = '0;
      if (en) begin
         case (mode)
            2'd1: begin
               if (m_q.size() > 0) nt = m_q.pop_front();
               else if (m_ucnt < 65535) m_ucnt++;
            end
            2'd2: begin
`ifdef TX_PRBS_EN
               if (m_prev != 2'd2) seed();
               for (int i = 0; i < NTI; i++) begin
                  b = m_hist[m_hist.size()-6] ^ m_hist[m_hist.size()-7];
                  m_hist.push_back(b);
                  nt[i] = b;
               end
`endif
            end
            2'd3: nt = fixed_pattern;
            default: nt = '0;
         endcase
         if (in_valid && rdy) m_q.push_back(in_data);
      end else begin
         m_q.delete();
      end
      m_tx = nt;
      m_valid = en;
      m_prev = mode;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_tx);
      #1;
   endtask

   task automatic test_reset();
      rstb = 1'b0; en = 1'b0; mode = 2'd0; in_valid = 1'b0;
      in_data = '0; fixed_pattern = '0;
      tick();
      tick();
      n_chk++;
      if (tx_data !== 16'h0000) begin
         n_fail++; $display("FAIL reset_tx got %h exp 0000", tx_data);
      end
      n_chk++;
      if (tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b exp 0", tx_valid);
      end
      n_chk++;
      if (fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level);
      end
      n_chk++;
      if (underflow_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_ucnt got %0d exp 0", underflow_cnt);
      end
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready);
      end
      rstb = 1'b1;
   endtask

   task automatic test_fifo_stream();
      logic [NTI-1:0] exp_tx[6] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h0, 16'h0};
      logic [15:0]    exp_uc[6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
      en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         mode = (c == 0) ? 2'd0 : 2'd1;
         in_valid = (c < 3);
         in_data = NTI'(c + 1);
         tick();
         n_chk++;
         if (tx_data !== exp_tx[c] || tx_data !== m_tx) begin
            n_fail++;
            $display("FAIL stream_tx c%0d got %h exp %h", c, tx_data, exp_tx[c]);
         end
         n_chk++;
         if (underflow_cnt !== exp_uc[c]) begin
            n_fail++;
            $display("FAIL stream_ucnt c%0d got %0d exp %0d", c, underflow_cnt, exp_uc[c]);
         end
         n_chk++;
         if (fifo_level !== 3'(m_q.size())) begin
            n_fail++;
            $display("FAIL stream_level c%0d got %0d exp %0d", c, fifo_level, m_q.size());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full();
      en = 1'b0;
      tick();
      en = 1'b1; mode = 2'd0; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_data = NTI'($urandom);
         tick();
         n_chk++;
         if (fifo_level !== 3'(m_q.size()) || in_ready !== (m_q.size() < NF)) begin
            n_fail++;
            $display("FAIL full_fill c%0d got lvl %0d rdy %b exp lvl %0d", c, fifo_level, in_ready, m_q.size());
         end
      end
      n_chk++;
      if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_state got lvl %0d rdy %b exp lvl 4 rdy 0", fifo_level, in_ready);
      end
      in_valid = 1'b0; mode = 2'd1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_chk++;
         if (tx_data !== m_tx || fifo_level !== 3'(m_q.size())) begin
            n_fail++;
            $display("FAIL full_drain c%0d got %h/%0d exp %h/%0d", c, tx_data, fifo_level, m_tx, m_q.size());
         end
      end
   endtask

   task automatic test_prbs();
      en = 1'b1; mode = 2'd0; in_valid = 1'b0;
      tick();
      for (int c = 0; c < 160; c++) begin
         mode = (c == 145) ? 2'd3 : 2'd2;
         en = !(c >= 127 && c < 130);
         tick();
         n_chk++;
         if (tx_data !== m_tx || tx_valid !== m_valid) begin
            n_fail++;
            $display("FAIL prbs c%0d got %h/%b exp %h/%b", c, tx_data, tx_valid, m_tx, m_valid);
         end
      end
   endtask

   task automatic test_fixed();
      en = 1'b0; mode = 2'd3; fixed_pattern = 16'hA5A5;
      tick();
      en = 1'b1;
      tick();
      n_chk++;
      if (tx_data !== 16'hA5A5 || tx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fixed_on got %h/%b exp a5a5/1", tx_data, tx_valid);
      end
      fixed_pattern = NTI'($urandom);
      tick();
      n_chk++;
      if (tx_data !== m_tx) begin
         n_fail++; $display("FAIL fixed_rand got %h exp %h", tx_data, m_tx);
      end
      en = 1'b0;
      tick();
      n_chk++;
      if (tx_data !== 16'h0000 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fixed_off got %h/%b exp 0000/0", tx_data, tx_valid);
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; mode = 2'd1; in_valid = 1'b0;
      tick();
      mode = 2'd0; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_data = NTI'($urandom);
         tick();
      end
      in_valid = 1'b0;
      n_chk++;
      if (fifo_level !== 3'd3 || underflow_cnt === 16'd0) begin
         n_fail++;
         $display("FAIL rmid_pre got lvl %0d ucnt %0d exp lvl 3 ucnt>0", fifo_level, underflow_cnt);
      end
      rstb = 1'b0;
      tick();
      n_chk++;
      if (fifo_level !== 3'd0 || tx_data !== 16'h0 || underflow_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rmid_rst got lvl %0d tx %h ucnt %0d exp 0", fifo_level, tx_data, underflow_cnt);
      end
      rstb = 1'b1; mode = 2'd2;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_chk++;
         if (tx_data !== m_tx) begin
            n_fail++; $display("FAIL rmid_mode2 c%0d got %h exp %h", c, tx_data, m_tx);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rstb = ($urandom_range(0, 49) != 0);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
         in_valid = $urandom_range(0, 1);
         in_data = NTI'($urandom);
         fixed_pattern = NTI'($urandom);
         tick();
         n_chk++;
         if (tx_data !== m_tx || tx_valid !== m_valid || fifo_level !== 3'(m_q.size())
             || in_ready !== (m_q.size() < NF) || underflow_cnt !== 16'(m_ucnt)) begin
            n_fail++;
            $display("FAIL random c%0d got %h/%b/%0d/%b/%0d exp %h/%b/%0d/%0d", c,
                     tx_data, tx_valid, fifo_level, in_ready, underflow_cnt,
                     m_tx, m_valid, m_q.size(), m_ucnt);
         end
      end
   endtask

   initial begin
      seed();
      m_tx = '0; m_valid = 1'b0; m_ucnt = 0; m_prev = 2'd0;
      test_reset();
      test_fifo_stream();
      test_full();
      test_prbs();
      test_fixed();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_data_path.md
TX_DATA_PATH -- requirements
Module: tx_data_path

Interface
REQ-001 Parameter Nti, default 16: transmit word width in bits per clk_tx cycle; bit 0 is first in time on the line.
REQ-002 Parameter Nfifo, default 4: input FIFO depth in words; a power of two, at least 2.
REQ-003 clk_tx  input  1  transmit word clock; all logic is on its rising edge.
REQ-004 rstb  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  datapath enable.
REQ-006 mode  input  2  source select: 0 idle zeros, 1 FIFO data, 2 PRBS7, 3 fixed pattern.
REQ-007 in_data  input  Nti  word offered to the FIFO.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  FIFO can accept a word this cycle.
REQ-010 fixed_pattern  input  Nti  word sent in mode 3.
REQ-011 tx_data  output  Nti  registered word to the analog serializer.
REQ-012 tx_valid  output  1  registered; tx_data is meaningful.
REQ-013 fifo_level  output  $clog2(Nfifo)+1  current number of FIFO entries.
REQ-014 underflow_cnt  output  16  saturating count of FIFO underflow cycles.

Function
REQ-015 FIFO write occurs on a cycle with in_valid=1 and in_ready=1; in_ready = (fifo_level < Nfifo), combinational from the level only.
REQ-016 FIFO read occurs on a cycle with en=1, mode=1 and fifo_level>0; the popped word appears on tx_data at the next rising edge (1-cycle latency).
REQ-017 Simultaneous write and read: level unchanged, both take effect; write to an empty FIFO is not bypassed to tx_data in the same cycle.
REQ-018 Full FIFO: in_ready=0, the offered word is not stored, and no error is flagged.
REQ-019 Underflow: en=1, mode=1, fifo_level=0 -> next tx_data=0 and underflow_cnt increments; it holds at 16'hFFFF.
REQ-020 Mode 0: next tx_data=0.
REQ-021 Mode 3: next tx_data=fixed_pattern.
REQ-022 Mode 2: PRBS7 (x^7+x^6+1) is advanced Nti bits per cycle; tx_data[i] is the i-th bit generated.
REQ-023 The PRBS state seeds to 7'h7F on reset and on any cycle where mode changes into 2; the sequence is continuous across cycles otherwise.
REQ-024 The next tx_valid equals the current en.
REQ-025 en=0: next tx_data=0, FIFO flushed (level -> 0), no read, PRBS state held; in_ready follows the flushed level from the next cycle.
REQ-026 Mode changes take effect on the next tx_data; FIFO contents are preserved across mode changes while en=1.

Reset
REQ-027 rstb=0 at a rising edge sets tx_data=0, tx_valid=0, fifo_level=0, underflow_cnt=0 and PRBS state=7'h7F, and discards FIFO contents.
REQ-028 Reset mid-stream discards any in-flight word; the first post-reset output is determined solely by inputs sampled after rstb=1.

Configuration
REQ-029 Macro TX_PRBS_EN defined: the PRBS7 generator and mode 2 operate as in REQ-022/023.
REQ-030 Macro TX_PRBS_EN undefined: no PRBS logic is built, mode 2 behaves exactly as mode 0, and all other behaviour is unchanged.

Verification
REQ-031 Reset, en=1, mode=1; push 16'h0001, 16'h0002, 16'h0003 back-to-back -> tx_data shows 0001, 0002, 0003 on consecutive cycles after a 1-cycle latency, followed by 0 with underflow_cnt incrementing from 0.
REQ-032 en=1, mode=0; push 5 words with in_valid held high (Nfifo=4) -> in_ready drops after 4 writes, fifo_level=4, and the 5th word is not stored.
REQ-033 mode=2 (TX_PRBS_EN defined), en=1 for 127 cycles -> the concatenated bitstream matches a reference PRBS7 seeded with 7'h7F and repeats with period 127 bits.
REQ-034 mode=3, fixed_pattern=16'hA5A5, en=1 -> tx_data=A5A5 and tx_valid=1 from the cycle after en rises; en drops -> tx_data=0 and tx_valid=0 on the next cycle.
REQ-035 Fill FIFO to 3 entries, then assert rstb=0 for one cycle -> fifo_level=0, tx_data=0, underflow_cnt=0; with TX_PRBS_EN undefined, mode=2 -> tx_data=0.
